afisaj_numarator: RTL and testbench



---
 rtl/afisaj_numarator.sv | 109 ++++++++++
 tb/tb_afisaj_numarator.sv | 106 ++++++++++
 2 files changed

// File: rtl/afisaj_numarator.sv
// afisaj_numarator: double-dabble binary-to-BCD converter driving a 2-digit multiplexed 7-segment display
// Optional leading-zero blanking of the tens digit: AFISAJ_BLANK_ZERO_EN
module afisaj_numarator #(
    parameter int W           = 5,
    parameter int REFRESH_DIV = 1024
) (
    input  logic         ck,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic [6:0]   seg,
    output logic [1:0]   an,
    output logic         busy
);
    localparam int CW = $clog2(W + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0]  last, last_nx, shreg, shreg_nx;
    logic [7:0]    bcd, bcd_nx, adj;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    units, units_nx, tens, tens_nx, digit;
    logic [RW-1:0] rc;
    logic          sel;
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
    endfunction
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= '0;
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            units <= '0;
            tens  <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            shreg <= shreg_nx;
            bcd   <= bcd_nx;
            cnt   <= cnt_nx;
            units <= units_nx;
            tens  <= tens_nx;
        end
    end
    // add-3 correction is applied before each shift, so no final fix-up is needed
    assign adj = {bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4],
                  bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0]};
    always_comb begin
        state_nx = state;
        last_nx  = last;
        shreg_nx = shreg;
        bcd_nx   = bcd;
        cnt_nx   = cnt;
        units_nx = units;
        tens_nx  = tens;
        case (state)
            IDLE: if (in != last) begin
                last_nx  = in;
                shreg_nx = in;
                bcd_nx   = '0;
                cnt_nx   = '0;
                state_nx = CONV;
            end
            CONV: begin
                {bcd_nx, shreg_nx} = {adj, shreg} << 1;
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(W - 1)) state_nx = DONE;
            end
            DONE: begin
                units_nx = bcd[3:0];
                tens_nx  = bcd[7:4];
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            rc  <= '0;
            sel <= 1'b0;
        end else if (rc == RW'(REFRESH_DIV - 1)) begin
            rc  <= '0;
            sel <= ~sel;
        end else begin
            rc <= rc + RW'(1);
        end
    end
    assign busy  = state != IDLE;
    assign digit = sel ? tens : units;
    assign an    = sel ? 2'b01 : 2'b10;
`ifdef AFISAJ_BLANK_ZERO_EN
    assign seg = (sel && tens == 4'd0) ? 7'b1111111 : dec(digit);
`else
    assign seg = dec(digit);
`endif
endmodule

// File: tb/tb_afisaj_numarator.sv
// tb_afisaj_numarator: directed checks of conversion latency, digit display, multiplexing and reset
module tb_afisaj_numarator;
    localparam int RD = 4;
    logic       ck = 1'b0, reset = 1'b0;
    logic [4:0] in = '0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       busy;
    int n = 0, fails = 0, cyc = 0;

    afisaj_numarator #(.W(5), .REFRESH_DIV(RD)) dut (
        .ck(ck), .reset(reset), .in(in), .seg(seg), .an(an), .busy(busy)
    );

    always #5 ck = ~ck;

    function automatic logic [6:0] tdec(input int d);
        logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic logic [6:0] exp_seg(input int u, input int t, input logic s);
`ifdef AFISAJ_BLANK_ZERO_EN
        if (s && t == 0) return 7'b1111111;
`endif
        return s ? tdec(t) : tdec(u);
    endfunction

    task automatic check(input string tag, input logic eb, input int u, input int t, input logic s);
        logic [1:0] ea;
        logic [6:0] es;
        ea = s ? 2'b01 : 2'b10;
        es = exp_seg(u, t, s);
        n += 3;
        assert (busy === eb) else begin fails++; $error("FAIL %s busy obs=%b exp=%b cyc=%0d", tag, busy, eb, cyc); end
        assert (an === ea) else begin fails++; $error("FAIL %s an obs=%b exp=%b cyc=%0d", tag, an, ea, cyc); end
        assert (seg === es) else begin fails++; $error("FAIL %s seg obs=%b exp=%b cyc=%0d", tag, seg, es, cyc); end
    endtask

    task automatic step(input string tag, input logic eb, input int u, input int t);
        @(posedge ck);
        #1;
        cyc++;
        check(tag, eb, u, t, 1'((cyc / RD) % 2));
    endtask

    task automatic steps(input int k, input string tag, input logic eb, input int u, input int t);
        for (int i = 0; i < k; i++) step(tag, eb, u, t);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(posedge ck);
            #1;
            check("reset_hold", 1'b0, 0, 0, 1'b0);
        end
        reset = 1'b1;
        cyc = 0;
        steps(5, "idle_after_reset", 1'b0, 0, 0);

        in = 5'd22;
        steps(6, "conv22_busy", 1'b1, 0, 0);
        steps(8, "show22", 1'b0, 2, 2);

        in = 5'd31;
        steps(6, "conv31_busy", 1'b1, 2, 2);
        steps(9, "show31", 1'b0, 1, 3);

        in = 5'd7;
        steps(6, "conv7_busy", 1'b1, 1, 3);
        steps(8, "show7", 1'b0, 7, 0);

        in = 5'd22;
        steps(2, "chg_conv22", 1'b1, 7, 0);
        in = 5'd9;
        steps(4, "chg_conv22_rest", 1'b1, 7, 0);
        step("chg_idle22", 1'b0, 2, 2);
        steps(6, "chg_conv9", 1'b1, 2, 2);
        steps(8, "show9", 1'b0, 9, 0);

        in = 5'd22;
        steps(3, "rst_conv22", 1'b1, 9, 0);
        reset = 1'b0;
        #1;
        check("rst_async", 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge ck);
            #1;
            check("rst_mid_hold", 1'b0, 0, 0, 1'b0);
        end
        reset = 1'b1;
        cyc = 0;
        steps(6, "post_rst_conv22", 1'b1, 0, 0);
        steps(8, "post_rst_show22", 1'b0, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
